float_mult_8bit_pipe: RTL and testbench
=======================================

FLOAT_MULT_8BIT_PIPE -- requirements
Module: float_mult_8bit_pipe

Interface
REQ-001 The block SHALL have parameter BIAS, default 7, giving the exponent bias of the 1-4-3 operand format.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1, which marks the operand pair as valid.
REQ-005 The block SHALL have port in_ready, output, 1, which indicates the block accepts an operand pair this cycle.
REQ-006 The block SHALL have ports opa and opb, input, 8 each, carrying the operands {sign[7], exp[6:3], frac[2:0]}.
REQ-007 The block SHALL have port out_valid, output, 1, which marks prod and the flags as valid.
REQ-008 The block SHALL have port out_ready, input, 1, driven by the downstream float adder stage, which consumes the result.
REQ-009 The block SHALL have port prod, output, 8, carrying the product in the same 1-4-3 format.
REQ-010 The block SHALL have ports overflow and underflow, output, 1 each, as flags qualified by out_valid.

Function
REQ-011 An operand pair SHALL transfer on a cycle with in_valid=1 and in_ready=1; a result SHALL transfer on a cycle with out_valid=1 and out_ready=1.
REQ-012 Structure: three register stages. S1 captures operands. S2 holds sign, the 8-bit mantissa product and the signed 6-bit exponent sum. S3 holds the normalized, rounded result driving the outputs.
REQ-013 Each stage k SHALL load when its valid_k=0 or stage k+1 loads (S3 loads when out_valid=0 or out_ready=1); bubbles SHALL collapse.
REQ-014 in_ready SHALL equal the S1 load condition and SHALL be combinational from out_ready and the stage valids only, never from in_valid.
REQ-015 Latency SHALL be 3 cycles from an accepted input to out_valid with no stall; throughput SHALL be one result per cycle.
REQ-016 While out_valid=1 and out_ready=0, prod, overflow and underflow SHALL hold stable; no result SHALL be lost, duplicated or reordered.
REQ-017 Sign SHALL be opa[7] XOR opb[7].
REQ-018 Mantissa: an operand with exp field 0 SHALL be treated as zero (denormals flushed); otherwise its mantissa SHALL be {1, frac} (4 bits), and P SHALL be the 8-bit product of the two mantissas.
REQ-019 Exponent E SHALL be ea + eb - BIAS, computed as a signed value of at least 6 bits.
REQ-020 Normalization: if P[7]=1, the result SHALL take m=P[6:4], g=P[3], s=|P[2:0] and E+1; otherwise m=P[5:3], g=P[2], s=|P[1:0].
REQ-021 Rounding SHALL be round-to-nearest-even: increment m when g & (s | m[0]); if m was 111, the carry SHALL set m=000 and E+1.
REQ-022 Overflow: if final E >= 15, prod SHALL be {sign, 1111, 111} with overflow=1 and underflow=0.
REQ-023 Underflow: if final E <= 0, prod SHALL be {sign, 0000, 000} with underflow=1 and overflow=0.
REQ-024 Zero: if either operand is zero, prod SHALL be {sign, 0000000} with both flags 0, overriding REQ-022 and REQ-023.
REQ-025 Otherwise, prod SHALL be {sign, E[3:0], m} with both flags 0.

Reset
REQ-026 With rst=1 at a clock edge, all stage valids, out_valid, prod, overflow and underflow SHALL be 0 after that edge.
REQ-027 During rst=1, in_ready SHALL be 0 and no input SHALL be accepted.
REQ-028 Reset asserted mid-stream SHALL discard every in-flight operation; the first result after reset SHALL come from an input accepted after rst deasserts.

Verification
REQ-029 The bench SHALL cover a basic multiply: 0x38 x 0x38 with out_ready=1 -> prod=0x38, flags 0, out_valid exactly 3 cycles after acceptance.
REQ-030 The bench SHALL cover round-up and carry: 0x3D x 0x3D -> 0x43; 0x3E x 0x39 -> 0x40 (mantissa carry increments the exponent); 0x3C x 0x3C -> 0x41.
REQ-031 The bench SHALL cover saturation and flush: 0x70 x 0x70 -> 0x7F, overflow=1; 0xF0 x 0x70 -> 0xFF, overflow=1; 0x08 x 0x08 -> 0x00, underflow=1; 0x00 x 0x3C -> 0x00, flags 0.
REQ-032 The bench SHALL cover backpressure: stream 5 pairs back-to-back with out_ready=0. in_ready SHALL fall after 3 acceptances and prod SHALL stay stable. Then release out_ready; all 5 results SHALL emerge in order with no gaps.
REQ-033 The bench SHALL cover bubble collapse: stimulus in_valid=1,0,1 with out_ready=0 -> both items resident, in_ready still 1 for a third acceptance.
REQ-034 The bench SHALL cover mid-stream reset: assert rst for 1 cycle with 2 items in flight -> out_valid=0 next cycle; the next result SHALL correspond to the first post-reset input.

Source files
------------

// File: rtl/float_mult_8bit_pipe.sv
// Three-stage pipelined multiplier for 8-bit 1-4-3 floats (sign, 4-bit exponent,
// 3-bit fraction). Denormal operands flush to zero, rounding is nearest-even,
// out-of-range results saturate. A valid/ready handshake on both sides, with
// per-stage load enables, lets bubbles collapse under backpressure.
module float_mult_8bit_pipe #(
    parameter int BIAS = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] opa,
    input  logic [7:0] opb,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] prod,
    output logic       overflow,
    output logic       underflow
);

    localparam logic signed [5:0] BIAS_S = 6'(BIAS);

    // Normalize the raw mantissa product and round to nearest-even.
    // Returns {exponent[6:0] (signed), mantissa fraction[2:0]}.
    function automatic logic [9:0] norm_round(input logic [7:0] p,
                                              input logic signed [5:0] e);
        logic [2:0]        m;
        logic              g;
        logic              s;
        logic signed [6:0] ex;
        ex = {e[5], e};
        if (p[7]) begin
            m  = p[6:4];
            g  = p[3];
            s  = |p[2:0];
            ex = ex + 7'sd1;
        end else begin
            m  = p[5:3];
            g  = p[2];
            s  = |p[1:0];
        end
        if (g && (s || m[0])) begin
            if (m == 3'b111) begin
                ex = ex + 7'sd1;
            end
            m = m + 3'd1;
        end
        return {ex, m};
    endfunction

    // Apply zero override and saturation. Returns {overflow, underflow, prod[7:0]}.
    function automatic logic [9:0] saturate(input logic sign, input logic zero,
                                            input logic signed [6:0] ex,
                                            input logic [2:0] m);
        if (zero) begin
            return {2'b00, sign, 7'h00};
        end
        if (ex >= 7'sd15) begin
            return {2'b10, sign, 7'h7F};
        end
        if (ex <= 7'sd0) begin
            return {2'b01, sign, 7'h00};
        end
        return {2'b00, sign, ex[3:0], m};
    endfunction

    logic              vld_p0, vld_p1, vld_p2;
    logic              ld_p0, ld_p1, ld_p2;
    logic [7:0]        a_p0, b_p0;
    logic              sign_p1, zero_p1;
    logic [7:0]        mant_p1;
    logic signed [5:0] exp_p1;

    // A stage may load when empty or when its successor is loading.
    assign ld_p2     = !vld_p2 || out_ready;
    assign ld_p1     = !vld_p1 || ld_p2;
    assign ld_p0     = !vld_p0 || ld_p1;
    assign in_ready  = ld_p0 && !rst;
    assign out_valid = vld_p2;

    // S1 -> S2 combinational: sign, mantissa product, biased exponent sum
    logic [3:0]        ma, mb;
    logic [7:0]        mant_prod;
    logic signed [5:0] ea_s, eb_s, exp_sum;
    logic              a_zero, b_zero;

    assign a_zero    = (a_p0[6:3] == 4'd0);
    assign b_zero    = (b_p0[6:3] == 4'd0);
    assign ma        = a_zero ? 4'd0 : {1'b1, a_p0[2:0]};
    assign mb        = b_zero ? 4'd0 : {1'b1, b_p0[2:0]};
    assign mant_prod = {4'd0, ma} * {4'd0, mb};
    assign ea_s      = $signed({2'b00, a_p0[6:3]});
    assign eb_s      = $signed({2'b00, b_p0[6:3]});
    assign exp_sum   = ea_s + eb_s - BIAS_S;

    // S2 -> S3 combinational: normalize, round, saturate
    logic [9:0] nr;
    logic [9:0] res;

    assign nr  = norm_round(mant_p1, exp_p1);
    assign res = saturate(sign_p1, zero_p1, $signed(nr[9:3]), nr[2:0]);

    // Stage S1 (p0) valid: take in_valid whenever the stage loads
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
        end else if (ld_p0) begin
            vld_p0 <= in_valid;
        end
    end

    // Stage S1 (p0) data: capture operands on an accepted transfer
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            a_p0 <= opa;
            b_p0 <= opb;
        end
    end

    // Stage S2 (p1) valid: advance from S1
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (ld_p1) begin
            vld_p1 <= vld_p0;
        end
    end

    // Stage S2 (p1) data: sign, mantissa product, exponent sum, zero flag
    always_ff @(posedge clk) begin
        if (ld_p1 && vld_p0) begin
            sign_p1 <= a_p0[7] ^ b_p0[7];
            zero_p1 <= a_zero || b_zero;
            mant_p1 <= mant_prod;
            exp_p1  <= exp_sum;
        end
    end

    // Stage S3 (p2): registered outputs, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2    <= 1'b0;
            prod      <= 8'h00;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (ld_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                overflow  <= res[9];
                underflow <= res[8];
                prod      <= res[7:0];
            end
        end
    end

endmodule

// File: tb/tb_float_mult_8bit_pipe.sv
// Self-checking bench for float_mult_8bit_pipe: directed vectors, backpressure,
// bubble collapse, mid-stream reset and a randomized stream against a
// behavioural model.
module tb_float_mult_8bit_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] opa = 8'h00;
    logic [7:0] opb = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] prod;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_q[$];
    logic [9:0] sb_exp;
    logic [9:0] held_val;
    bit         held = 0;

    float_mult_8bit_pipe #(.BIAS(7)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opa(opa), .opb(opb), .out_valid(out_valid), .out_ready(out_ready),
        .prod(prod), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Reference model working on operand values: exact integer product,
    // rounding decided by comparing the discarded remainder with one half.
    // Returns {overflow, underflow, prod}.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b);
        int   ea, eb, ma, mb, p, e, sh, m, rem, half;
        logic s;
        s  = a[7] ^ b[7];
        ea = int'(a[6:3]);
        eb = int'(b[6:3]);
        if (ea == 0 || eb == 0) return {2'b00, s, 7'h00};
        ma = 8 + int'(a[2:0]);
        mb = 8 + int'(b[2:0]);
        p  = ma * mb;
        e  = ea + eb - 7;
        sh = (p >= 128) ? 4 : 3;
        if (p >= 128) e = e + 1;
        m    = p >> sh;
        rem  = p % (1 << sh);
        half = 1 << (sh - 1);
        if (rem > half || (rem == half && (m % 2) == 1)) m = m + 1;
        if (m == 16) begin
            m = 8;
            e = e + 1;
        end
        if (e >= 15) return {2'b10, s, 7'h7F};
        if (e <= 0) return {2'b01, s, 7'h00};
        return {2'b00, s, 4'(e), 3'(m - 8)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on accepted input, pop on consumed output, check stall stability
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                held = 0;
            end else begin
                if (in_valid && in_ready) exp_q.push_back(model(opa, opb));
                if (out_valid) begin
                    if (held) begin
                        checks++;
                        if ({overflow, underflow, prod} !== held_val) begin
                            errors++;
                            $display("FAIL stall_stable: got %h expected %h",
                                     {overflow, underflow, prod}, held_val);
                        end
                    end
                    if (out_ready) begin
                        checks++;
                        held = 0;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL sb_unexpected: got %h expected no output",
                                     {overflow, underflow, prod});
                        end else begin
                            sb_exp = exp_q.pop_front();
                            if ({overflow, underflow, prod} !== sb_exp) begin
                                errors++;
                                $display("FAIL sb_result: got %h expected %h",
                                         {overflow, underflow, prod}, sb_exp);
                            end
                        end
                    end else begin
                        held     = 1;
                        held_val = {overflow, underflow, prod};
                    end
                end else begin
                    held = 0;
                end
            end
        end
    end

    // Single transaction on an idle pipe: check latency, product and flags.
    task automatic run_vec(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] ep, input logic eo, input logic eu);
        int k;
        step();
        opa = a;
        opb = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            chk({name, "_accept"}, 0, 1);
            in_valid = 1'b0;
            return;
        end
        step();
        in_valid = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 10);
        chk({name, "_latency"}, k, 3);
        chk({name, "_prod"}, prod, ep);
        chk({name, "_flags"}, {overflow, underflow}, {eo, eu});
    endtask

    logic [7:0] bp_a[5] = '{8'h38, 8'h3D, 8'h3E, 8'h3C, 8'h40};
    logic [7:0] bp_b[5] = '{8'h38, 8'h3D, 8'h39, 8'h3C, 8'h40};

    initial begin
        int  idx;
        int  seen;
        int  k;
        bit  acc;
        bit  gap;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_prod", prod, 0);
        chk("rst_flags", {overflow, underflow}, 0);
        chk("rst_in_ready", in_ready, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // Directed vectors
        run_vec("basic",     8'h38, 8'h38, 8'h38, 1'b0, 1'b0);
        run_vec("round_up",  8'h3D, 8'h3D, 8'h43, 1'b0, 1'b0);
        run_vec("carry",     8'h3E, 8'h39, 8'h40, 1'b0, 1'b0);
        run_vec("norm_hi",   8'h3C, 8'h3C, 8'h41, 1'b0, 1'b0);
        run_vec("ovf_pos",   8'h70, 8'h70, 8'h7F, 1'b1, 1'b0);
        run_vec("ovf_neg",   8'hF0, 8'h70, 8'hFF, 1'b1, 1'b0);
        run_vec("udf",       8'h08, 8'h08, 8'h00, 1'b0, 1'b1);
        run_vec("zero",      8'h00, 8'h3C, 8'h00, 1'b0, 1'b0);

        // Backpressure: five back-to-back pairs with the consumer stalled
        step();
        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1;
        opa = bp_a[0];
        opb = bp_b[0];
        repeat (6) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            step();
            if (acc) begin
                idx++;
                if (idx < 5) begin
                    opa = bp_a[idx];
                    opb = bp_b[idx];
                end else in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("bp_accepts", idx, 3);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        step();
        out_ready = 1'b1;
        seen = 0;
        gap  = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid) seen++;
            else if (seen > 0 && seen < 5) gap = 1;
            step();
            if (acc) begin
                idx++;
                if (idx < 5) begin
                    opa = bp_a[idx];
                    opb = bp_b[idx];
                end else in_valid = 1'b0;
            end
        end
        chk("bp_result_count", seen, 5);
        chk("bp_no_gaps", gap, 0);

        // Bubble collapse: in_valid 1,0,1 with the consumer stalled
        step();
        out_ready = 1'b0;
        in_valid = 1'b1;
        opa = 8'h41;
        opb = 8'h3A;
        @(negedge clk);
        chk("bub_first", in_ready, 1);
        step();
        in_valid = 1'b0;
        step();
        in_valid = 1'b1;
        opa = 8'h44;
        opb = 8'h45;
        @(negedge clk);
        chk("bub_second", in_ready, 1);
        step();
        opa = 8'hC2;
        opb = 8'h3B;
        @(negedge clk);
        chk("bub_third_ready", in_ready, 1);
        chk("bub_out_valid", out_valid, 1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bub_full", in_ready, 0);
        step();
        out_ready = 1'b1;
        repeat (6) step();

        // Mid-stream reset with two items in flight
        in_valid = 1'b1;
        opa = 8'h48;
        opb = 8'h3B;
        step();
        opa = 8'h50;
        opb = 8'h41;
        step();
        rst = 1'b1;
        opa = 8'h70;
        opb = 8'h38;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 0);
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        run_vec("post_rst", 8'h3A, 8'h3B, 8'h3E, 1'b0, 1'b0);

        // Randomized stream with random backpressure
        step();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                opa = {1'($urandom), 4'($urandom_range(4, 10)), 3'($urandom)};
                opb = {1'($urandom), 4'($urandom_range(4, 10)), 3'($urandom)};
            end else begin
                opa = 8'($urandom);
                opb = 8'($urandom);
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (exp_q.size() > 0 && k < 50) begin
            step();
            k++;
        end
        repeat (2) step();
        chk("drain_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
